// File: rtl/int_queue_drain_pkg.sv
// Shared definitions for the interrupt queue drain controller: FSM encoding
// and the legal read-latency range of the interrupt queue.
package int_queue_drain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 2;

    // Down-counter wide enough to hold READ_LATENCY_MAX-1.
    localparam int WAIT_CNT_WIDTH = 2;

    function automatic bit read_latency_legal(input int lat);
        return (lat >= READ_LATENCY_MIN) && (lat <= READ_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/int_queue_drain.sv
// Pops interrupt events one at a time from the interrupt queue, presents each
// to the host until acknowledged, and keeps an event count and sticky ECC flags.
//
// state | meaning
// IDLE  | queue empty, nothing presented
// POP   | fifoRdEn asserted for one cycle
// WAIT  | waiting READ_LATENCY cycles for read data; last cycle captures
// HOLD  | event presented on intStatus until intClr
module int_queue_drain
    import int_queue_drain_pkg::*;
#(
    parameter int FIFO_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fifoEmpty,
    input  logic [FIFO_WIDTH-1:0] fifoRdData,
    input  logic                  errSb,
    input  logic                  errDb,
    input  logic                  intClr,
    input  logic                  intMask,
    input  logic                  errClr,
    output logic                  fifoRdEn,
    output logic [FIFO_WIDTH-1:0] intStatus,
    output logic                  intStatusValid,
    output logic                  interrupt,
    output logic [CNT_WIDTH-1:0]  eventCnt,
    output logic                  errSbSticky,
    output logic                  errDbSticky
);

    if (!read_latency_legal(READ_LATENCY)) begin : g_bad_latency
        $error("int_queue_drain: READ_LATENCY must be 1 or 2");
    end

    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD = WAIT_CNT_WIDTH'(READ_LATENCY - 1);
    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_ONE  = WAIT_CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]      CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]      CNT_MAX   = '1;

    state_t                      state;
    state_t                      state_next;
    logic [WAIT_CNT_WIDTH-1:0]   wait_cnt;
    logic [WAIT_CNT_WIDTH-1:0]   wait_cnt_next;
    logic                        capture;
    logic                        clear_valid;
    logic                        pop;
    logic                        status_valid_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        capture       = 1'b0;
        clear_valid   = 1'b0;
        pop           = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifoEmpty) begin
                    state_next = ST_POP;
                end
            end
            ST_POP: begin
                pop           = 1'b1;
                wait_cnt_next = WAIT_LOAD;
                state_next    = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    capture    = 1'b1;
                    state_next = ST_HOLD;
                end else begin
                    wait_cnt_next = wait_cnt - WAIT_ONE;
                end
            end
            ST_HOLD: begin
                if (intClr) begin
                    clear_valid = 1'b1;
                    state_next  = fifoEmpty ? ST_IDLE : ST_POP;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Gated by reset so a reset landing on a POP cycle never pops the shared queue.
    assign fifoRdEn = pop && !reset;

    always_comb begin
        status_valid_next = intStatusValid;
        if (capture) begin
            status_valid_next = 1'b1;
        end else if (clear_valid) begin
            status_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            intStatus      <= '0;
            intStatusValid <= 1'b0;
            interrupt      <= 1'b0;
            eventCnt       <= '0;
            errSbSticky    <= 1'b0;
            errDbSticky    <= 1'b0;
        end else begin
            if (capture) begin
                intStatus <= fifoRdData;
            end
            intStatusValid <= status_valid_next;
            interrupt      <= status_valid_next & ~intMask;
            if (pop && (eventCnt != CNT_MAX)) begin
                eventCnt <= eventCnt + CNT_ONE;
            end
            // A new error in the same cycle as errClr wins.
            errSbSticky <= (errSbSticky & ~errClr) | (capture & errSb);
            errDbSticky <= (errDbSticky & ~errClr) | (capture & errDb);
        end
    end

endmodule

// File: tb/tb_int_queue_drain.sv
// Directed bench for int_queue_drain: instance A uses READ_LATENCY=1 with a
// 3-bit counter, instance B uses READ_LATENCY=2 with the default counter.
module tb_int_queue_drain;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    logic       a_reset, a_empty, a_err_sb, a_err_db, a_int_clr, a_int_mask, a_err_clr;
    logic [7:0] a_data;
    logic       a_rd_en, a_valid, a_int, a_sb_st, a_db_st;
    logic [7:0] a_status;
    logic [2:0] a_cnt;

    logic        b_reset, b_empty, b_err_sb, b_err_db, b_int_clr, b_int_mask, b_err_clr;
    logic [7:0]  b_data;
    logic        b_rd_en, b_valid, b_int, b_sb_st, b_db_st;
    logic [7:0]  b_status;
    logic [15:0] b_cnt;

    int_queue_drain #(.FIFO_WIDTH(8), .READ_LATENCY(1), .CNT_WIDTH(3)) u_dut_a (
        .clock(clock), .reset(a_reset), .fifoEmpty(a_empty), .fifoRdData(a_data),
        .errSb(a_err_sb), .errDb(a_err_db), .intClr(a_int_clr), .intMask(a_int_mask),
        .errClr(a_err_clr), .fifoRdEn(a_rd_en), .intStatus(a_status),
        .intStatusValid(a_valid), .interrupt(a_int), .eventCnt(a_cnt),
        .errSbSticky(a_sb_st), .errDbSticky(a_db_st)
    );

    int_queue_drain #(.FIFO_WIDTH(8), .READ_LATENCY(2), .CNT_WIDTH(16)) u_dut_b (
        .clock(clock), .reset(b_reset), .fifoEmpty(b_empty), .fifoRdData(b_data),
        .errSb(b_err_sb), .errDb(b_err_db), .intClr(b_int_clr), .intMask(b_int_mask),
        .errClr(b_err_clr), .fifoRdEn(b_rd_en), .intStatus(b_status),
        .intStatusValid(b_valid), .interrupt(b_int), .eventCnt(b_cnt),
        .errSbSticky(b_sb_st), .errDbSticky(b_db_st)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        a_empty = 1'b0; a_int_clr = 1'b1; a_err_clr = 1'b1;
        tick(); tick();
        vectors++; if (a_rd_en !== 1'b0) begin miscompares++; $display("FAIL rst_a_rd_en: got %0h expected 0", a_rd_en); end
        vectors++; if (a_status !== 8'h00) begin miscompares++; $display("FAIL rst_a_status: got %0h expected 0", a_status); end
        vectors++; if (a_valid !== 1'b0) begin miscompares++; $display("FAIL rst_a_valid: got %0h expected 0", a_valid); end
        vectors++; if (a_int !== 1'b0) begin miscompares++; $display("FAIL rst_a_int: got %0h expected 0", a_int); end
        vectors++; if (a_cnt !== 3'd0) begin miscompares++; $display("FAIL rst_a_cnt: got %0h expected 0", a_cnt); end
        vectors++; if ({a_sb_st, a_db_st} !== 2'b00) begin miscompares++; $display("FAIL rst_a_sticky: got %0h expected 0", {a_sb_st, a_db_st}); end
        vectors++; if ({b_rd_en, b_valid, b_int} !== 3'b000) begin miscompares++; $display("FAIL rst_b_ctl: got %0h expected 0", {b_rd_en, b_valid, b_int}); end
        vectors++; if (b_cnt !== 16'd0) begin miscompares++; $display("FAIL rst_b_cnt: got %0h expected 0", b_cnt); end
        a_empty = 1'b1; a_int_clr = 1'b0; a_err_clr = 1'b0;
        a_reset = 1'b0; b_reset = 1'b0;
        tick();
        vectors++; if (a_rd_en !== 1'b0) begin miscompares++; $display("FAIL rst_idle_rd_en: got %0h expected 0", a_rd_en); end
    endtask

    task automatic test_single_event();
        a_empty = 1'b0; a_data = 8'hFF;
        tick();
        vectors++; if (a_rd_en !== 1'b1) begin miscompares++; $display("FAIL s1_pop: got %0h expected 1", a_rd_en); end
        vectors++; if (a_valid !== 1'b0) begin miscompares++; $display("FAIL s1_valid_early: got %0h expected 0", a_valid); end
        a_empty = 1'b1;
        tick();
        vectors++; if (a_rd_en !== 1'b0) begin miscompares++; $display("FAIL s1_pop_once: got %0h expected 0", a_rd_en); end
        a_data = 8'h5A;
        tick();
        a_data = 8'hC3;
        vectors++; if (a_status !== 8'h5A) begin miscompares++; $display("FAIL s1_status: got %0h expected 5a", a_status); end
        vectors++; if (a_valid !== 1'b1) begin miscompares++; $display("FAIL s1_valid: got %0h expected 1", a_valid); end
        vectors++; if (a_int !== 1'b1) begin miscompares++; $display("FAIL s1_int: got %0h expected 1", a_int); end
        vectors++; if (a_cnt !== 3'd1) begin miscompares++; $display("FAIL s1_cnt: got %0h expected 1", a_cnt); end
        tick();
        vectors++; if (a_status !== 8'h5A) begin miscompares++; $display("FAIL s1_hold_stable: got %0h expected 5a", a_status); end
        a_int_clr = 1'b1;
        tick();
        a_int_clr = 1'b0;
        vectors++; if ({a_valid, a_int} !== 2'b00) begin miscompares++; $display("FAIL s1_ack: got %0h expected 0", {a_valid, a_int}); end
        tick();
        vectors++; if (a_rd_en !== 1'b0) begin miscompares++; $display("FAIL s1_idle: got %0h expected 0", a_rd_en); end
    endtask

    task automatic test_back_to_back();
        a_empty = 1'b0;
        tick();
        vectors++; if (a_rd_en !== 1'b1) begin miscompares++; $display("FAIL b2b_pop1: got %0h expected 1", a_rd_en); end
        tick();
        a_data = 8'h11;
        tick();
        vectors++; if (a_status !== 8'h11) begin miscompares++; $display("FAIL b2b_status1: got %0h expected 11", a_status); end
        vectors++; if (a_cnt !== 3'd2) begin miscompares++; $display("FAIL b2b_cnt1: got %0h expected 2", a_cnt); end
        vectors++; if (a_rd_en !== 1'b0) begin miscompares++; $display("FAIL b2b_no_pop_held: got %0h expected 0", a_rd_en); end
        a_int_clr = 1'b1;
        tick();
        a_int_clr = 1'b0;
        vectors++; if ({a_rd_en, a_valid} !== 2'b10) begin miscompares++; $display("FAIL b2b_pop2: got %0h expected 2", {a_rd_en, a_valid}); end
        a_empty = 1'b1;
        tick();
        a_data = 8'h22;
        tick();
        vectors++; if (a_status !== 8'h22) begin miscompares++; $display("FAIL b2b_status2: got %0h expected 22", a_status); end
        vectors++; if (a_cnt !== 3'd3) begin miscompares++; $display("FAIL b2b_cnt2: got %0h expected 3", a_cnt); end
        a_int_clr = 1'b1;
        tick();
        a_int_clr = 1'b0;
        vectors++; if (a_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_ack: got %0h expected 0", a_valid); end
    endtask

    task automatic test_clr_ignored();
        a_int_clr = 1'b1;
        tick();
        a_int_clr = 1'b0;
        vectors++; if ({a_rd_en, a_valid} !== 2'b00) begin miscompares++; $display("FAIL ign_idle: got %0h expected 0", {a_rd_en, a_valid}); end
        vectors++; if (a_cnt !== 3'd3) begin miscompares++; $display("FAIL ign_idle_cnt: got %0h expected 3", a_cnt); end
        a_empty = 1'b0;
        tick();
        a_empty = 1'b1;
        tick();
        a_int_clr = 1'b1; a_data = 8'h3C;
        tick();
        a_int_clr = 1'b0;
        vectors++; if ({a_valid, a_status} !== {1'b1, 8'h3C}) begin miscompares++; $display("FAIL ign_wait: got %0h expected 13c", {a_valid, a_status}); end
        vectors++; if (a_cnt !== 3'd4) begin miscompares++; $display("FAIL ign_wait_cnt: got %0h expected 4", a_cnt); end
        tick();
        vectors++; if ({a_valid, a_rd_en} !== 2'b10) begin miscompares++; $display("FAIL ign_still_held: got %0h expected 2", {a_valid, a_rd_en}); end
        a_int_clr = 1'b1;
        tick();
        a_int_clr = 1'b0;
    endtask

    task automatic test_err_sticky();
        a_empty = 1'b0;
        tick();
        a_empty = 1'b1; a_err_sb = 1'b1;
        tick();
        a_err_sb = 1'b0; a_err_db = 1'b1; a_data = 8'h77;
        tick();
        a_err_db = 1'b0;
        vectors++; if ({a_sb_st, a_db_st} !== 2'b01) begin miscompares++; $display("FAIL err_capture: got %0h expected 1", {a_sb_st, a_db_st}); end
        vectors++; if (a_cnt !== 3'd5) begin miscompares++; $display("FAIL err_cnt: got %0h expected 5", a_cnt); end
        a_int_clr = 1'b1;
        tick();
        a_int_clr = 1'b0;
        vectors++; if ({a_db_st, a_valid} !== 2'b10) begin miscompares++; $display("FAIL err_hold_through_ack: got %0h expected 2", {a_db_st, a_valid}); end
        a_empty = 1'b0;
        tick();
        a_empty = 1'b1;
        tick();
        a_err_db = 1'b1; a_err_sb = 1'b1; a_err_clr = 1'b1; a_data = 8'h78;
        tick();
        a_err_db = 1'b0; a_err_sb = 1'b0; a_err_clr = 1'b0;
        vectors++; if ({a_sb_st, a_db_st} !== 2'b11) begin miscompares++; $display("FAIL err_set_beats_clr: got %0h expected 3", {a_sb_st, a_db_st}); end
        vectors++; if (a_cnt !== 3'd6) begin miscompares++; $display("FAIL err_cnt2: got %0h expected 6", a_cnt); end
        a_err_clr = 1'b1; a_int_clr = 1'b1;
        tick();
        a_err_clr = 1'b0; a_int_clr = 1'b0;
        vectors++; if ({a_sb_st, a_db_st, a_valid} !== 3'b000) begin miscompares++; $display("FAIL err_clear: got %0h expected 0", {a_sb_st, a_db_st, a_valid}); end
    endtask

    task automatic test_saturate_and_reset();
        a_empty = 1'b0;
        tick();
        tick();
        a_data = 8'h01;
        tick();
        vectors++; if (a_cnt !== 3'd7) begin miscompares++; $display("FAIL sat_reach: got %0h expected 7", a_cnt); end
        a_int_clr = 1'b1;
        tick();
        a_int_clr = 1'b0; a_empty = 1'b1;
        tick();
        a_data = 8'h02;
        tick();
        vectors++; if ({a_cnt, a_status} !== {3'd7, 8'h02}) begin miscompares++; $display("FAIL sat_hold: got %0h expected 702", {a_cnt, a_status}); end
        a_int_clr = 1'b1;
        tick();
        a_int_clr = 1'b0; a_empty = 1'b0;
        tick();
        a_empty = 1'b1;
        tick();
        a_reset = 1'b1; a_int_clr = 1'b1; a_err_clr = 1'b1; a_err_db = 1'b1; a_data = 8'h99;
        tick();
        a_reset = 1'b0; a_int_clr = 1'b0; a_err_clr = 1'b0; a_err_db = 1'b0;
        vectors++; if ({a_rd_en, a_valid, a_int, a_db_st} !== 4'b0000) begin miscompares++; $display("FAIL rstw_ctl: got %0h expected 0", {a_rd_en, a_valid, a_int, a_db_st}); end
        vectors++; if ({a_cnt, a_status} !== 11'd0) begin miscompares++; $display("FAIL rstw_data: got %0h expected 0", {a_cnt, a_status}); end
        tick();
        vectors++; if ({a_rd_en, a_valid} !== 2'b00) begin miscompares++; $display("FAIL rstw_idle: got %0h expected 0", {a_rd_en, a_valid}); end
        a_empty = 1'b0;
        tick();
        vectors++; if (a_rd_en !== 1'b1) begin miscompares++; $display("FAIL rstw_resume: got %0h expected 1", a_rd_en); end
        a_empty = 1'b1;
    endtask

    task automatic test_mask_latency2();
        b_int_mask = 1'b1; b_empty = 1'b0;
        tick();
        vectors++; if (b_rd_en !== 1'b1) begin miscompares++; $display("FAIL l2_pop: got %0h expected 1", b_rd_en); end
        b_empty = 1'b1; b_data = 8'hEE;
        tick();
        tick();
        vectors++; if (b_valid !== 1'b0) begin miscompares++; $display("FAIL l2_not_early: got %0h expected 0", b_valid); end
        b_data = 8'hA5;
        tick();
        b_data = 8'h00;
        vectors++; if ({b_valid, b_status} !== {1'b1, 8'hA5}) begin miscompares++; $display("FAIL l2_capture: got %0h expected 1a5", {b_valid, b_status}); end
        vectors++; if (b_int !== 1'b0) begin miscompares++; $display("FAIL l2_masked: got %0h expected 0", b_int); end
        vectors++; if (b_cnt !== 16'd1) begin miscompares++; $display("FAIL l2_cnt: got %0h expected 1", b_cnt); end
        b_int_mask = 1'b0;
        tick();
        vectors++; if (b_int !== 1'b1) begin miscompares++; $display("FAIL l2_unmask: got %0h expected 1", b_int); end
        b_int_mask = 1'b1;
        tick();
        vectors++; if ({b_int, b_valid, b_status} !== {2'b01, 8'hA5}) begin miscompares++; $display("FAIL l2_remask: got %0h expected a5 with valid", {b_int, b_valid, b_status}); end
        b_int_clr = 1'b1;
        tick();
        b_int_clr = 1'b0;
        vectors++; if (b_valid !== 1'b0) begin miscompares++; $display("FAIL l2_ack: got %0h expected 0", b_valid); end
    endtask

    initial begin
        a_reset = 1'b1; a_empty = 1'b1; a_data = 8'h00; a_err_sb = 1'b0; a_err_db = 1'b0;
        a_int_clr = 1'b0; a_int_mask = 1'b0; a_err_clr = 1'b0;
        b_reset = 1'b1; b_empty = 1'b1; b_data = 8'h00; b_err_sb = 1'b0; b_err_db = 1'b0;
        b_int_clr = 1'b0; b_int_mask = 1'b0; b_err_clr = 1'b0;
        test_reset();
        test_single_event();
        test_back_to_back();
        test_clr_ignored();
        test_err_sticky();
        test_saturate_and_reset();
        test_mask_latency2();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/int_queue_drain.md
INT_QUEUE_DRAIN -- requirements
Module: int_queue_drain

Interface
REQ-001 Parameter FIFO_WIDTH, default 8: interrupt event word width; matches the interrupt queue.
REQ-002 Parameter READ_LATENCY, default 1, legal 1..2: cycles from fifoRdEn to valid fifoRdData.
REQ-003 Parameter CNT_WIDTH, default 16: width of the event counter.
REQ-004 Port clock, in, 1: single clock; all logic on its rising edge.
REQ-005 Port reset, in, 1: synchronous, active-high reset.
REQ-006 Port fifoEmpty, in, 1: interrupt queue empty flag.
REQ-007 Port fifoRdData, in, FIFO_WIDTH: queue read data.
REQ-008 Port errSb, in, 1: queue ECC single-bit-corrected flag, aligned with fifoRdData.
REQ-009 Port errDb, in, 1: queue ECC double-bit-detected flag, aligned with fifoRdData.
REQ-010 Port intClr, in, 1: host acknowledge pulse for the presented event.
REQ-011 Port intMask, in, 1: masks the interrupt output only.
REQ-012 Port errClr, in, 1: clears the sticky error flags.
REQ-013 Port fifoRdEn, out, 1: queue pop strobe.
REQ-014 Port intStatus, out, FIFO_WIDTH: currently presented event word.
REQ-015 Port intStatusValid, out, 1: intStatus holds an unacknowledged event.
REQ-016 Port interrupt, out, 1: interrupt request to the host.
REQ-017 Port eventCnt, out, CNT_WIDTH: saturating count of events popped.
REQ-018 Port errSbSticky, out, 1; errDbSticky, out, 1: sticky ECC flags.

Function
REQ-019 FSM states SHALL be IDLE, POP, WAIT and HOLD.
REQ-020 IDLE -> POP when fifoEmpty=0; otherwise stay in IDLE.
REQ-021 fifoRdEn SHALL be 1 only in POP, for exactly one cycle per event.
REQ-022 POP -> WAIT unconditionally; WAIT SHALL last READ_LATENCY cycles, tracked by a down-counter.
REQ-023 On the final WAIT cycle the block SHALL register fifoRdData into intStatus, set intStatusValid, and enter HOLD.
REQ-024 Latency from fifoEmpty falling in IDLE to intStatusValid high SHALL be READ_LATENCY+2 cycles.
REQ-025 In HOLD, intStatus SHALL stay stable; intClr=1 SHALL clear intStatusValid, then go to POP if fifoEmpty=0, else to IDLE.
REQ-026 intClr outside HOLD SHALL be ignored.
REQ-027 interrupt SHALL equal intStatusValid AND NOT intMask, registered with no added latency relative to intStatusValid.
REQ-028 intMask SHALL NOT stall draining or alter intStatus.
REQ-029 eventCnt SHALL increment on each POP cycle and saturate at all-ones, with no wrap.
REQ-030 errSb/errDb SHALL be sampled on the capture cycle and OR-set errSbSticky/errDbSticky.
REQ-031 errClr SHALL clear both sticky flags; a set and an errClr in the same cycle SHALL leave the flag set.
REQ-032 No pop SHALL be issued while intStatusValid=1; at most one event is outstanding.
REQ-033 fifoRdData/errSb/errDb outside the capture cycle SHALL be ignored.

Reset
REQ-034 reset=1 SHALL force IDLE, fifoRdEn=0, intStatus=0, intStatusValid=0, interrupt=0, eventCnt=0, both sticky flags=0, WAIT counter=0.
REQ-035 reset SHALL take priority over all inputs, including intClr and errClr in the same cycle.
REQ-036 Reset mid-POP or mid-WAIT SHALL abandon the in-flight event; the interrupt queue shares this reset, so no event is duplicated.

Structure
REQ-037 A shared package SHALL hold the FSM state encoding (2-bit) and the READ_LATENCY legal-range constants.
REQ-038 A single flat module, no sub-module; the FSM, WAIT counter, event counter and sticky flags all live in one file.

Verification
REQ-039 Scenario, READ_LATENCY=1: queue holds 0x5A, fifoEmpty falls at cycle 0 -> fifoRdEn at cycle 1; intStatus=0x5A, intStatusValid=1 and interrupt=1 at cycle 3; eventCnt=1.
REQ-040 Scenario, back-to-back: queue holds 0x11, 0x22; intClr in HOLD -> next cycle POP with no IDLE, intStatus=0x22 two cycles later (L=1), eventCnt=2.
REQ-041 Scenario, READ_LATENCY=2, intMask=1: one event 0xA5 -> intStatusValid at cycle 4, interrupt stays 0; release intMask -> interrupt=1 next cycle.
REQ-042 Scenario: errDb=1 on the capture cycle -> errDbSticky=1 and held through intClr; errClr with a simultaneous errDb -> stays 1; errClr alone -> 0.
REQ-043 Scenario: eventCnt preset to all-ones-1, two events drained -> eventCnt=all-ones and holds; reset asserted during WAIT -> all outputs 0 and IDLE next cycle.
REQ-044 Scenario: intClr pulses in IDLE and in WAIT -> no state change, no extra pop, eventCnt unchanged.
